mousetrap_entry_arbiter: RTL and testbench
==========================================

// Module: mousetrap_entry_arbiter
// PURPOSE
//  Synchronous round-robin arbiter sharing the entry stage of the MouseTrap latch/C-element pipeline among N_REQ
//  clocked requesters. Grants one requester, registers its word onto the bundled-data bus, issues a two-phase
//  (transition) request to pipeline stage 0, then waits for the stage's two-phase acknowledge before granting again.
// PARAMETERS
//  N_REQ        4   number of requesters (1..16)
//  DATA_W       8   width of each data word
//  SYNC_STAGES  2   flops in PipeAck synchronizer (2..4); used only when MT_ACK_SYNC_EN defined
// PORTS
//  Clk       in   1             system clock, all state on rising edge
//  Reset     in   1             synchronous, active-high reset
//  ReqIn     in   N_REQ         level request per requester; hold with DataIn stable until granted
//  DataIn    in   N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
//  GrantOut  out  N_REQ         one-hot, one-cycle pulse: requester's word captured this edge
//  PipeReq   out  1             two-phase request to stage 0 (each toggle = one new token)
//  PipeData  out  DATA_W        bundled data to stage 0
//  PipeAck   in   1             two-phase acknowledge from stage 0 (asynchronous to Clk)
//  Busy      out  1             1 while a token is outstanding (SETUP or WAIT)
//  AckErr    out  1             sticky: PipeAck toggled with no token outstanding
// BEHAVIOUR
//  Reset (sync, active-high, Clk edge): state=IDLE, PipeReq=0, PipeData=0, GrantOut=0, Busy=0, AckErr=0,
//   RR pointer=0, sync flops=0. Reset dominates all other inputs. Stage 0 shares Reset, so both sides restart at phase 0.
//  AckS = synchronized PipeAck (see CONFIGURATION). Token complete when AckS == PipeReq.
//  FSM:
//   IDLE : if ReqIn!=0 -> winner = first set bit at index >= pointer, wrapping to 0;
//          PipeData<=DataIn[winner], GrantOut<=onehot(winner) for 1 cycle, pointer<=(winner+1) mod N_REQ, -> SETUP.
//          ReqIn==0 -> stay, outputs held.
//   SETUP: PipeData stable one full cycle (bundled-data setup margin); PipeReq<=~PipeReq, Busy=1, -> WAIT.
//   WAIT : Busy=1; PipeData, PipeReq held. When AckS==PipeReq -> IDLE (Busy=0 next cycle). No timeout.
//  Busy is registered: 1 from the SETUP edge until the edge leaving WAIT.
//  Min token period: 3 Clk + ack sync latency. Grant-to-PipeReq toggle latency: exactly 1 cycle.
//  Round robin: granted requester gets lowest priority next round; continuous requesters served cyclically.
//  N_REQ=1: pointer constant 0; single requester granted every token slot.
//  Requester may keep ReqIn high after GrantOut to queue the next word (must update DataIn the cycle after grant).
//  ReqIn dropped before grant: request simply withdrawn, no state change.
//  AckS != PipeReq in IDLE or SETUP (spurious toggle): AckErr<=1 (sticky until Reset); FSM not disturbed.
//  Reset during WAIT: token abandoned, PipeReq returns to 0 together with pipeline reset; no grant lost-tracking.
//  PipeData never changes while Busy=1.
// CONFIGURATION
//  MT_ACK_SYNC_EN defined: PipeAck passes SYNC_STAGES flops before use (AckS latency SYNC_STAGES cycles);
//   required in silicon since PipeAck comes from the asynchronous latch controller.
//  MT_ACK_SYNC_EN undefined: AckS = PipeAck sampled directly by the FSM (0-cycle sync); for simulation with a
//   clocked pipeline model only; SYNC_STAGES ignored. Min token period becomes 3 cycles.
// TESTING
//  Reset=1 5 cycles, then 0 -> PipeReq=0, PipeData=0, GrantOut=0, Busy=0, AckErr=0.
//  ReqIn=4'b0100, DataIn[2]=8'hA5; model acks 2 cycles after each toggle -> GrantOut=4'b0100 1 cycle,
//   PipeData=8'hA5, PipeReq 0->1 next cycle, Busy=1 until AckS=1, back to IDLE.
//  ReqIn=4'b1111 held, words 8'h10..8'h13 -> grants 0,1,2,3,0 in order; PipeReq toggles once per grant.
//  Delay ack 50 cycles with ReqIn=4'b0011 -> no second grant, PipeData/PipeReq constant until ack.
//  Toggle PipeAck while IDLE -> AckErr=1 and stays 1; subsequent grant/ack sequence still completes.
//  Assert Reset in WAIT with PipeReq=1 -> next cycle PipeReq=0, Busy=0, pointer=0; new request grants normally.

Source files
------------

// File: rtl/mousetrap_entry_arbiter.sv
// ============================================================================
// Module      : mousetrap_entry_arbiter
// Description : Round-robin arbiter feeding the entry stage of a MouseTrap
//               two-phase bundled-data pipeline. Optional PipeAck synchronizer
//               enabled by defining MT_ACK_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mousetrap_entry_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          ReqIn,
    input  logic [N_REQ*DATA_W-1:0]   DataIn,
    output logic [N_REQ-1:0]          GrantOut,
    output logic                      PipeReq,
    output logic [DATA_W-1:0]         PipeData,
    input  logic                      PipeAck,
    output logic                      Busy,
    output logic                      AckErr
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    if (N_REQ < 1 || N_REQ > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
        $error("mousetrap_entry_arbiter: parameter out of range");
    end

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [N_REQ-1:0]    r_grant;
    logic                r_pipe_req;
    logic [DATA_W-1:0]   r_data;
    logic                r_busy;
    logic                r_ack_err;

    logic                w_ack_s;
    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_ptr_next;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_idx;
    logic [N_REQ-1:0]    w_onehot;
    logic [DATA_W-1:0]   w_data;

`ifdef MT_ACK_SYNC_EN
    // PipeAck is produced by the asynchronous latch controller; resynchronize.
    logic [SYNC_STAGES-1:0] r_ack_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], PipeAck};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
`else
    assign w_ack_s = PipeAck;
`endif

    // Search starts at the pointer and wraps, so the last winner is lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(N_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(N_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && ReqIn[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        if (w_win == PTR_W'(N_REQ-1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_win + PTR_W'(1);
        end
    end

    assign w_onehot = N_REQ'(1) << w_win;
    assign w_data   = DataIn[int'(w_win)*DATA_W +: DATA_W];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_pipe_req <= 1'b0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_grant <= '0;
            // With no token outstanding the acknowledge phase must match the request phase.
            if (r_state != ST_WAIT && w_ack_s != r_pipe_req) begin
                r_ack_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_data  <= w_data;
                        r_grant <= w_onehot;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_pipe_req <= ~r_pipe_req;
                    r_busy     <= 1'b1;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_ack_s == r_pipe_req) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GrantOut = r_grant;
    assign PipeReq  = r_pipe_req;
    assign PipeData = r_data;
    assign Busy     = r_busy;
    assign AckErr   = r_ack_err;

endmodule

`default_nettype wire

// File: tb/tb_mousetrap_entry_arbiter.sv
// ============================================================================
// Module      : tb_mousetrap_entry_arbiter
// Description : Scoreboard bench for mousetrap_entry_arbiter with a clocked
//               two-phase stage-0 acknowledge model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mousetrap_entry_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;

    logic                     Clk = 1'b0;
    logic                     Reset = 1'b1;
    logic [N_REQ-1:0]         ReqIn = '0;
    logic [N_REQ*DATA_W-1:0]  DataIn = '0;
    logic                     PipeAck = 1'b0;
    logic [N_REQ-1:0]         GrantOut;
    logic                     PipeReq;
    logic [DATA_W-1:0]        PipeData;
    logic                     Busy;
    logic                     AckErr;

    mousetrap_entry_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_W     (DATA_W),
        .SYNC_STAGES(2)
    ) u_dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .ReqIn   (ReqIn),
        .DataIn  (DataIn),
        .GrantOut(GrantOut),
        .PipeReq (PipeReq),
        .PipeData(PipeData),
        .PipeAck (PipeAck),
        .Busy    (Busy),
        .AckErr  (AckErr)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [N_REQ-1:0]  g;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   ack_delay = 2;
    bit   model_en = 1'b1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Stage-0 model: answers each new request phase after ack_delay cycles.
    int model_cnt = 0;
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset) begin
                model_cnt = 0;
            end else if (model_en && PipeReq !== PipeAck) begin
                model_cnt++;
                if (model_cnt >= ack_delay) begin
                    PipeAck   = PipeReq;
                    model_cnt = 0;
                end
            end else begin
                model_cnt = 0;
            end
        end
    end

    logic             m_prev_busy = 1'b0;
    logic [DATA_W-1:0] m_prev_data = '0;
    logic             m_prev_req = 1'b0;
    bit               m_exp_tog = 1'b0;
    logic             m_tog_val = 1'b0;
    exp_t             m_e;

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (Reset) begin
                m_exp_tog   = 1'b0;
                m_prev_busy = 1'b0;
            end else begin
                if (m_exp_tog) begin
                    check("req_toggle", 32'(PipeReq), 32'(m_tog_val));
                    check("busy_after_grant", 32'(Busy), 32'd1);
                    m_exp_tog = 1'b0;
                end
                if (m_prev_busy && Busy) begin
                    check("data_stable", 32'(PipeData), 32'(m_prev_data));
                    check("req_stable", 32'(PipeReq), 32'(m_prev_req));
                end
                if (GrantOut != '0) begin
                    if (q.size() == 0) begin
                        check("unexpected_grant", 32'(GrantOut), 32'd0);
                    end else begin
                        m_e = q.pop_front();
                        check("grant", 32'(GrantOut), 32'(m_e.g));
                        check("grant_data", 32'(PipeData), 32'(m_e.d));
                        m_exp_tog = 1'b1;
                        m_tog_val = ~PipeReq;
                    end
                end
                m_prev_busy = Busy;
                m_prev_data = PipeData;
                m_prev_req  = PipeReq;
            end
        end
    end

    task automatic do_reset(input int n);
        Reset   = 1'b1;
        PipeAck = 1'b0;
        repeat (n) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic wait_grant(output int cyc);
        bit got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge Clk);
            cyc++;
            if (GrantOut != '0) got = 1'b1;
        end
        check("grant_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_done();
        bit up = 1'b0;
        bit down = 1'b0;
        for (int i = 0; i < 20 && !up; i++) begin
            @(negedge Clk);
            if (Busy) up = 1'b1;
        end
        for (int i = 0; i < 300 && up && !down; i++) begin
            @(negedge Clk);
            if (!Busy) down = 1'b1;
        end
        check("token_done", 32'(down), 32'd1);
    endtask

    function automatic void push(input logic [N_REQ-1:0] g, input logic [DATA_W-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        q.push_back(e);
    endfunction

    initial begin
        int c;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        do_reset(5);
        check("rst_pipereq", 32'(PipeReq), 32'd0);
        check("rst_pipedata", 32'(PipeData), 32'd0);
        check("rst_grant", 32'(GrantOut), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ackerr", 32'(AckErr), 32'd0);

        // Single requester 2
        DataIn[2*DATA_W +: DATA_W] = 8'hA5;
        push(4'b0100, 8'hA5);
        ReqIn = 4'b0100;
        wait_grant(c);
        ReqIn = '0;
        wait_done();
        check("single_pipereq", 32'(PipeReq), 32'd1);
        check("single_busy", 32'(Busy), 32'd0);

        // Continuous requesters from a fresh pointer
        do_reset(2);
        for (int i = 0; i < N_REQ; i++) DataIn[i*DATA_W +: DATA_W] = 8'(8'h10 + i);
        push(4'b0001, 8'h10);
        push(4'b0010, 8'h11);
        push(4'b0100, 8'h12);
        push(4'b1000, 8'h13);
        push(4'b0001, 8'h10);
        ReqIn = 4'b1111;
        for (int k = 0; k < 5; k++) wait_grant(c);
        ReqIn = '0;
        wait_done();
        check("rr_pipereq", 32'(PipeReq), 32'd1);

        // Slow acknowledge holds off the next grant (pointer now 1)
        ack_delay = 50;
        push(4'b0010, 8'h11);
        push(4'b0001, 8'h10);
        ReqIn = 4'b0011;
        wait_grant(c);
        wait_grant(c);
        ReqIn = '0;
        check("ack_hold_gap", 32'(c >= 50), 32'd1);
        wait_done();
        ack_delay = 2;

        // Spurious acknowledge toggle while idle
        model_en = 1'b0;
        @(negedge Clk);
        PipeAck = ~PipeAck;
        @(negedge Clk);
        check("ackerr_set", 32'(AckErr), 32'd1);
        PipeAck = ~PipeAck;
        repeat (3) @(negedge Clk);
        check("ackerr_sticky", 32'(AckErr), 32'd1);
        model_en = 1'b1;
        DataIn[3*DATA_W +: DATA_W] = 8'h5C;
        push(4'b1000, 8'h5C);
        ReqIn = 4'b1000;
        wait_grant(c);
        ReqIn = '0;
        wait_done();
        check("ackerr_after_token", 32'(AckErr), 32'd1);
        check("token_after_err", 32'(PipeReq), 32'(PipeAck));

        // Reset while waiting for acknowledge
        ack_delay = 50;
        DataIn[2*DATA_W +: DATA_W] = 8'hA5;
        push(4'b0100, 8'hA5);
        ReqIn = 4'b0100;
        wait_grant(c);
        ReqIn = '0;
        repeat (5) @(negedge Clk);
        check("wait_busy", 32'(Busy), 32'd1);
        check("wait_pipereq", 32'(PipeReq), 32'd1);
        do_reset(1);
        check("wrst_pipereq", 32'(PipeReq), 32'd0);
        check("wrst_busy", 32'(Busy), 32'd0);
        check("wrst_ackerr", 32'(AckErr), 32'd0);
        ack_delay = 2;
        DataIn[0 +: DATA_W] = 8'h10;
        push(4'b0001, 8'h10);
        ReqIn = 4'b1111;
        wait_grant(c);
        ReqIn = '0;
        wait_done();

        repeat (5) @(negedge Clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
